// File: rtl/four_bit_comparator.sv
// Registered magnitude comparator stage with lt/gt/eq cascade inputs for chaining wider compares.
// Define COMPARATOR_SIGNED_EN to compare a/b as two's-complement (build only the MSB stage that way).
module four_bit_comparator #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             lt_in,
  input  logic             gt_in,
  input  logic             eq_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;
  logic             local_gt;
  logic             local_lt;
  logic             lt_next;
  logic             gt_next;
  logic             eq_next;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
`ifdef COMPARATOR_SIGNED_EN
  always_comb begin
    a_key            = a;
    b_key            = b;
    a_key[WIDTH-1]   = ~a[WIDTH-1];
    b_key[WIDTH-1]   = ~b[WIDTH-1];
  end
`else
  always_comb begin
    a_key = a;
    b_key = b;
  end
`endif

  assign local_gt = (a_key > b_key);
  assign local_lt = (a_key < b_key);

  // Local operands dominate; on equality the cascade resolves gt_in > lt_in > eq.
  always_comb begin
    lt_next = 1'b0;
    gt_next = 1'b0;
    eq_next = 1'b0;
    if (local_gt) begin
      gt_next = 1'b1;
    end else if (local_lt) begin
      lt_next = 1'b1;
    end else if (gt_in) begin
      gt_next = 1'b1;
    end else if (lt_in) begin
      lt_next = 1'b1;
    end else begin
      eq_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      lt        <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        lt <= lt_next;
        gt <= gt_next;
        eq <= eq_next;
      end
    end
  end

endmodule

// File: tb/tb_four_bit_comparator.sv
// Directed-vector bench for four_bit_comparator; results packed as {out_valid, lt, gt, eq}.
module tb_four_bit_comparator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       lt_in;
  logic       gt_in;
  logic       eq_in;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       lt;
  logic       gt;
  logic       eq;

  int unsigned checks;
  int unsigned failures;

  localparam logic [3:0] R_LT   = 4'b1100;
  localparam logic [3:0] R_GT   = 4'b1010;
  localparam logic [3:0] R_EQ   = 4'b1001;
  localparam logic [3:0] R_NONE = 4'b0000;

  four_bit_comparator #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .lt_in     (lt_in),
    .gt_in     (gt_in),
    .eq_in     (eq_in),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .lt        (lt),
    .gt        (gt),
    .eq        (eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got {v,lt,gt,eq}=%b expected %b", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the capturing rising edge.
  task automatic apply(input string tag, input logic [3:0] va, input logic [3:0] vb,
                       input logic l, input logic g, input logic e, input logic [3:0] exp);
    @(negedge clk);
    in_valid = 1'b1;
    a = va; b = vb; lt_in = l; gt_in = g; eq_in = e;
    @(posedge clk);
    #1;
    check(tag, {out_valid, lt, gt, eq}, exp);
  endtask

  task automatic idle(input string tag, input logic [3:0] exp);
    @(negedge clk);
    in_valid = 1'b0;
    a = 4'hF; b = 4'h0; lt_in = 1'b1; gt_in = 1'b0; eq_in = 1'b0;
    @(posedge clk);
    #1;
    check(tag, {out_valid, lt, gt, eq}, exp);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b1;
    a = 4'h3; b = 4'h1; lt_in = 1'b0; gt_in = 1'b0; eq_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", {out_valid, lt, gt, eq}, R_NONE);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset_idle", {out_valid, lt, gt, eq}, R_NONE);

    apply("equal_zero",      4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, R_EQ);
    apply("greater",         4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, R_GT);
    apply("less",            4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, R_LT);
    apply("gt_over_lt_in",   4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, R_GT);
    apply("lt_over_gt_in",   4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, R_LT);
    apply("pass_lt_in",      4'b1010, 4'b1010, 1'b1, 1'b0, 1'b0, R_LT);
    apply("pass_gt_in",      4'b1010, 4'b1010, 1'b0, 1'b1, 1'b0, R_GT);
    apply("pass_none",       4'b1010, 4'b1010, 1'b0, 1'b0, 1'b0, R_EQ);
    apply("illegal_casc",    4'b0110, 4'b0110, 1'b1, 1'b1, 1'b1, R_GT);
    apply("max_equal",       4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, R_EQ);
    apply("msb_diff",        4'b1000, 4'b0111, 1'b0, 1'b0, 1'b1,
`ifdef COMPARATOR_SIGNED_EN
          R_LT);
`else
          R_GT);
`endif
`ifdef COMPARATOR_SIGNED_EN
    apply("sign_f_vs_1",     4'b1111, 4'b0001, 1'b0, 1'b0, 1'b1, R_LT);
    idle("idle_hold",        4'b0100);
`else
    apply("sign_f_vs_1",     4'b1111, 4'b0001, 1'b0, 1'b0, 1'b1, R_GT);
    idle("idle_hold",        4'b0010);
`endif
    idle("idle_hold2",       {1'b0, R_GT[2:0]} & 4'b0000 | {1'b0,
`ifdef COMPARATOR_SIGNED_EN
          3'b100});
`else
          3'b010});
`endif

    apply("pre_reset",       4'b0011, 4'b0101, 1'b0, 1'b0, 1'b1, R_LT);
    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {out_valid, lt, gt, eq}, R_NONE);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", {out_valid, lt, gt, eq}, R_NONE);
    apply("first_after_rst", 4'b0101, 4'b0100, 1'b0, 1'b0, 1'b1, R_GT);
    apply("back_to_back",    4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1, R_EQ);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
